// File: rtl/fetch_exec_sequencer_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
// Optional feature macro used by the slice: SEQ_SINGLE_STEP_EN.
package seq_pkg;

    localparam int unsigned CTRL_W     = 13;
    localparam int unsigned ROM_ADDR_W = 7;

    // Control word bit positions
    localparam int unsigned CTRL_INC_PC     = 12;
    localparam int unsigned CTRL_LOAD_PC    = 11;
    localparam int unsigned CTRL_LOAD_A     = 10;
    localparam int unsigned CTRL_LOAD_FLAGS = 9;
    localparam int unsigned CTRL_ALU_SEL_HI = 8;
    localparam int unsigned CTRL_ALU_SEL_LO = 6;
    localparam int unsigned CTRL_CS_RAM     = 5;
    localparam int unsigned CTRL_WE_RAM     = 4;
    localparam int unsigned CTRL_OE_ALU     = 3;
    localparam int unsigned CTRL_OE_IN      = 2;
    localparam int unsigned CTRL_OE_OPRND   = 1;
    localparam int unsigned CTRL_LOAD_OUT   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FETCH = 2'd2,
        ST_EXEC  = 2'd3
    } seq_state_e;

    // Control ROM address: {opcode, carry, zero, phase}
    function automatic logic [ROM_ADDR_W-1:0] rom_addr_f(
        input logic [3:0] opcode,
        input logic       c,
        input logic       z,
        input logic       ph
    );
        return {opcode, c, z, ph};
    endfunction

endpackage

// File: rtl/fetch_exec_sequencer_if.sv
// Bus bundle between the sequencer and program memory / control ROM / datapath.
// SEQ_SINGLE_STEP_EN adds the step strobe.
interface fetch_exec_sequencer_if
    import seq_pkg::*;
#(
    parameter int PC_W = 12,
    parameter int IR_W = 8
);
`ifdef SEQ_SINGLE_STEP_EN
    logic                  step;
`endif
    logic                  run;
    logic [IR_W-1:0]       prog_data;
    logic                  prog_valid;
    logic [PC_W-1:0]       jmp_target;
    logic                  alu_c;
    logic                  alu_z;
    logic [CTRL_W-1:0]     ctrl_word;
    logic                  prog_req;
    logic [PC_W-1:0]       pc_out;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [3:0]            operand;
    logic [CTRL_W-1:0]     ctrl_out;
    logic                  phase;
    logic [1:0]            flags;
    logic                  busy;

    // Sequencer side
    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        input  run, prog_data, prog_valid, jmp_target, alu_c, alu_z, ctrl_word,
        output prog_req, pc_out, rom_addr, operand, ctrl_out, phase, flags, busy
    );

    // Environment side (memory, ROM, datapath)
    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        output run, prog_data, prog_valid, jmp_target, alu_c, alu_z, ctrl_word,
        input  prog_req, pc_out, rom_addr, operand, ctrl_out, phase, flags, busy
    );

endinterface

// File: rtl/fetch_exec_sequencer_pc_counter.sv
// Program counter: synchronous reset, load beats increment, wraps modulo 2^W.
module pc_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q, pc_d;

    // Next PC: load has priority, increment wraps naturally at W bits
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + W'(1);
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Instruction sequencer: owns PC, IR, flags and fetch/execute phase, addresses
// the control ROM and applies its control word back onto its own registers.
// Optional single-step start input enabled by SEQ_SINGLE_STEP_EN.
module fetch_exec_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 12,
    parameter int IR_W = 8
) (
    input logic                   clk,
    input logic                   reset,
    fetch_exec_sequencer_if.master bus
);

    seq_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [PC_W-1:0]   pc;
    logic              pc_load;
    logic              pc_inc;
    logic              in_fetch;
    logic              in_exec;
    logic              start;
    logic [CTRL_W-1:0] ctrl_act;

    // Phase decode, start condition and gated control word
    always_comb begin
        in_fetch = (state_q == ST_FETCH);
        in_exec  = (state_q == ST_EXEC);
`ifdef SEQ_SINGLE_STEP_EN
        start    = bus.run | bus.step;
`else
        start    = bus.run;
`endif
        ctrl_act = (in_fetch || in_exec) ? bus.ctrl_word : '0;
        pc_load  = in_exec & ctrl_act[CTRL_LOAD_PC];
        pc_inc   = ctrl_act[CTRL_INC_PC] & ~pc_load;
    end

    // Next-state, IR and flag update
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        c_d     = c_q;
        z_d     = z_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.prog_valid) begin
                    ir_d    = bus.prog_data;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (ctrl_act[CTRL_LOAD_FLAGS]) begin
                    c_d = bus.alu_c;
                    z_d = bus.alu_z;
                end
                state_d = bus.run ? ST_REQ : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, IR and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    pc_counter #(
        .W (PC_W)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_val_i (bus.jmp_target),
        .pc_o       (pc)
    );

    assign bus.prog_req = (state_q == ST_REQ);
    assign bus.pc_out   = pc;
    assign bus.rom_addr = rom_addr_f(ir_q[IR_W-1 -: 4], c_q, z_q, in_exec);
    assign bus.operand  = ir_q[3:0];
    assign bus.ctrl_out = ctrl_act;
    assign bus.phase    = in_exec;
    assign bus.flags    = {c_q, z_q};
    assign bus.busy     = in_fetch | in_exec;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Self-checking bench for fetch_exec_sequencer (SEQ_SINGLE_STEP_EN optional).
module tb_fetch_exec_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_exec_sequencer_if #(.PC_W(12), .IR_W(8)) bus ();

    fetch_exec_sequencer #(.PC_W(12), .IR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] pmem [0:4095];

    // Bench control ROM: fetch increments PC for any nonzero opcode
    function automatic logic [12:0] rom_fn(input logic [6:0] a);
        logic [3:0] op;
        op = a[6:3];
        if (!a[0]) return (op == 4'h0) ? 13'h0000 : 13'h1000;
        case (op)
            4'h2:    return 13'h0404;
            4'h3:    return 13'h1802;
            4'h4:    return 13'h0208;
            4'h6:    return a[2] ? 13'h0811 : 13'h0001;
            default: return 13'h0000;
        endcase
    endfunction

    assign bus.ctrl_word = rom_fn(bus.rom_addr);
    assign bus.prog_data = pmem[bus.pc_out];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [11:0] pc;
        logic [6:0]  fra;
        logic [6:0]  era;
        int          gap;
    } rec_t;

    rec_t sb[$];
    rec_t cur;
    bit   have_cur = 1'b0;
    int   cyc = 0;
    int   last_acc = 0;

    task automatic push(input logic [11:0] pc, input logic [7:0] ir,
                        input logic c, input logic z, input int gap);
        rec_t r;
        r.pc  = pc;
        r.fra = {ir[7:4], c, z, 1'b0};
        r.era = {ir[7:4], c, z, 1'b1};
        r.gap = gap;
        sb.push_back(r);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop on fetch acceptance, check ROM address / gated control per phase
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.prog_req && bus.prog_valid) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", sb.size(), 1);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    check_val("accept_pc", bus.pc_out, cur.pc);
                    if (cur.gap != 0) check_val("instr_gap", cyc - last_acc, cur.gap);
                end
                last_acc = cyc;
            end else if (bus.busy && have_cur) begin
                if (!bus.phase) begin
                    check_val("fetch_rom_addr", bus.rom_addr, cur.fra);
                    check_val("fetch_ctrl", bus.ctrl_out, rom_fn(cur.fra));
                    check_val("fetch_pc", bus.pc_out, cur.pc);
                end else begin
                    check_val("exec_rom_addr", bus.rom_addr, cur.era);
                    check_val("exec_ctrl", bus.ctrl_out, rom_fn(cur.era));
                end
            end
        end
    end

    task automatic wait_sb_empty(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check_val(tag, sb.size(), 0);
    endtask

    task automatic wait_idle(input string tag);
        bit idle = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.prog_req) begin
                idle = 1'b1;
                break;
            end
        end
        check_val(tag, idle, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) pmem[i] = 8'h00;
        reset          = 1'b1;
        bus.run        = 1'b0;
        bus.prog_valid = 1'b1;
        bus.jmp_target = 12'h3A5;
        bus.alu_c      = 1'b1;
        bus.alu_z      = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_prog_req", bus.prog_req, 0);
        check_val("rst_ctrl_out", bus.ctrl_out, 0);
        check_val("rst_phase", bus.phase, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_rom_addr", bus.rom_addr, 0);
        check_val("rst_pc", bus.pc_out, 0);
        check_val("rst_flags", bus.flags, 0);

        // Free run, prog_valid always high: 3 cycles per instruction
        pmem[0] = 8'h20; pmem[1] = 8'h20; pmem[2] = 8'h20;
        push(12'h000, 8'h20, 0, 0, 0);
        push(12'h001, 8'h20, 0, 0, 3);
        push(12'h002, 8'h20, 0, 0, 3);
        @(posedge clk); #1 bus.run = 1'b1;
        wait_sb_empty("seq_drain");
        bus.run = 1'b0;
        wait_idle("seq_idle");
        check_val("seq_end_pc", bus.pc_out, 12'h003);

        // Four wait states in REQ: request held, control gated to zero
        pmem[3] = 8'h20;
        bus.prog_valid = 1'b0;
        push(12'h003, 8'h20, 0, 0, 0);
        @(posedge clk); #1 bus.run = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.prog_req) begin seen = 1'b1; break; end
            end
            check_val("wait_req_seen", seen, 1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            check_val("wait_prog_req", bus.prog_req, 1);
            check_val("wait_ctrl_zero", bus.ctrl_out, 0);
            check_val("wait_busy", bus.busy, 0);
        end
        @(posedge clk); #1 bus.prog_valid = 1'b1;
        wait_sb_empty("wait_drain");
        bus.run = 1'b0;
        wait_idle("wait_idle");
        check_val("wait_end_pc", bus.pc_out, 12'h004);

        // Jump: loadPC beats incPC in EXEC
        pmem[4] = 8'h30; pmem[12'h3A5] = 8'h20;
        bus.jmp_target = 12'h3A5;
        push(12'h004, 8'h30, 0, 0, 0);
        push(12'h3A5, 8'h20, 0, 0, 3);
        @(posedge clk); #1 bus.run = 1'b1;
        wait_sb_empty("jmp_drain");
        bus.run = 1'b0;
        wait_idle("jmp_idle");
        check_val("jmp_end_pc", bus.pc_out, 12'h3A6);

        // Wrap: 0xFFF + 1 = 0x000
        pmem[12'h3A6] = 8'h30; pmem[12'hFFF] = 8'h20;
        bus.jmp_target = 12'hFFF;
        push(12'h3A6, 8'h30, 0, 0, 0);
        push(12'hFFF, 8'h20, 0, 0, 3);
        push(12'h000, 8'h20, 0, 0, 3);
        @(posedge clk); #1 bus.run = 1'b1;
        wait_sb_empty("wrap_drain");
        bus.run = 1'b0;
        wait_idle("wrap_idle");
        check_val("wrap_end_pc", bus.pc_out, 12'h001);

        // Flags latched in EXEC feed next rom_addr; reset during FETCH
        pmem[1] = 8'h40; pmem[2] = 8'h60;
        bus.alu_c = 1'b1;
        bus.alu_z = 1'b0;
        push(12'h001, 8'h40, 0, 0, 0);
        push(12'h002, 8'h60, 1, 0, 3);
        @(posedge clk); #1 bus.run = 1'b1;
        wait_sb_empty("flag_drain");
        bus.run = 1'b0;
        @(negedge clk);
        check_val("flag_fetch_busy", bus.busy, 1);
        check_val("flag_fetch_phase", bus.phase, 0);
        check_val("flag_value", bus.flags, 2'b10);
        check_val("flag_rom_bits", bus.rom_addr[2:1], 2'b10);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_req", bus.prog_req, 0);
        check_val("mid_rst_pc", bus.pc_out, 0);
        check_val("mid_rst_flags", bus.flags, 0);
        check_val("mid_rst_ctrl", bus.ctrl_out, 0);
        check_val("mid_rst_rom_addr", bus.rom_addr, 0);
        #1 reset = 1'b0;
        have_cur = 1'b0;
        @(negedge clk);
        check_val("post_rst_req", bus.prog_req, 0);

`ifdef SEQ_SINGLE_STEP_EN
        // Single step with run low; second step while busy ignored
        pmem[0] = 8'h20;
        push(12'h000, 8'h20, 0, 0, 0);
        @(posedge clk); #1 bus.step = 1'b1;
        @(posedge clk); #1 bus.step = 1'b0;
        @(posedge clk); #1 bus.step = 1'b1;
        @(posedge clk); #1 bus.step = 1'b0;
        wait_idle("step_idle");
        check_val("step_end_pc", bus.pc_out, 12'h001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("step_no_refetch", bus.prog_req | bus.busy, 0);
        end
`endif

        check_val("sb_leftover", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_exec_sequencer.md
# fetch_exec_sequencer

Instruction sequencer for the 4-bit microprocessor. It owns the program counter, instruction register, flag register and the fetch/execute phase bit. It forms the 7-bit address for the `opcode` control ROM and applies the returned 13-bit control word back onto its own registers. Control fan-out to the rest of the datapath is masked to zero whenever no instruction phase is active.

## Interface
- `PC_W`, 12: program counter / program-memory address width.
- `IR_W`, 8: instruction width; `{opcode[7:4], operand[3:0]}`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: free-run enable, sampled at instruction boundaries.
- `prog_data` in IR_W: instruction byte from program memory.
- `prog_valid` in 1: `prog_data` valid this cycle.
- `jmp_target` in PC_W: jump address from the operand path.
- `alu_c`, `alu_z` in 1: carry and zero from the ALU.
- `ctrl_word` in 13: control word from the ROM, combinational on `rom_addr`.
- `prog_req` out 1: fetch request to program memory.
- `pc_out` out PC_W: current PC.
- `rom_addr` out 7: `{opcode, c_q, z_q, phase}`.
- `operand` out 4: `IR[3:0]`.
- `ctrl_out` out 13: gated control word to the datapath.
- `phase` out 1: 0 = fetch, 1 = execute.
- `flags` out 2: `{c_q, z_q}`.
- `busy` out 1: high in FETCH or EXEC.

## Operation
- Control word bits, fixed: `[12]` incPC, `[11]` loadPC, `[10]` loadA, `[9]` loadFlags, `[8:6]` ALU sel, `[5]` csRAM, `[4]` weRAM, `[3]` oeALU, `[2]` oeIN, `[1]` oeOprnd, `[0]` loadOut.
- FSM states are IDLE, REQ, FETCH and EXEC.
- IDLE: `prog_req` = 0. Moves to REQ when `run` = 1.
- REQ: `prog_req` = 1 and `pc_out` = PC. When `prog_valid` = 1, IR is loaded from `prog_data` on that edge and the FSM moves to FETCH. Otherwise it holds, with no limit on wait states.
- FETCH: `phase` = 0 and `ctrl_out` = `ctrl_word`. An asserted incPC gives PC ← PC+1. Next state is EXEC.
- EXEC: `phase` = 1 and `ctrl_out` = `ctrl_word`.
  - loadPC gives PC ← `jmp_target`.
  - Otherwise, incPC gives PC+1.
  - loadFlags latches `alu_c` and `alu_z`.
  - Next state is REQ if `run` = 1, else IDLE.
- Priority: loadPC wins over incPC.
- PC arithmetic is modulo 2^PC_W: 0xFFF + 1 = 0x000.
- `ctrl_out` = 0 in IDLE and REQ, so there are no stray RAM or output strobes during wait states.
- A `run` deassert mid-instruction does not abort; the instruction finishes and the FSM parks in IDLE.
- Flags change only in EXEC with loadFlags. They are used by the next instruction's `rom_addr`.

## Timing
- Reset values: state IDLE, PC 0, IR 0, `c_q` = `z_q` = 0. Outputs: `prog_req` 0, `ctrl_out` 0, `phase` 0, `busy` 0, `rom_addr` 0.
- Minimum instruction time is 3 cycles: REQ with `prog_valid` high, then FETCH, then EXEC. Each wait cycle adds 1.
- `rom_addr` is combinational from the registered IR, flags and phase. It is stable for the whole FETCH or EXEC cycle.
- The IR is not written outside REQ; `prog_valid` outside REQ is ignored.
- `reset` in any state returns the block to IDLE with reset values on the next edge. Any pending fetch is abandoned.
- `run` rising while in IDLE gives REQ on the next cycle.

## Configuration
- `SEQ_SINGLE_STEP_EN` defined:
  - Adds the `step` input (1 bit).
  - In IDLE with `run` = 0, a one-cycle `step` pulse executes exactly one instruction (REQ → FETCH → EXEC) and then returns to IDLE.
  - `step` is ignored while `busy` or while in REQ.
- `SEQ_SINGLE_STEP_EN` undefined: there is no `step` port and only `run` starts fetches.

## Structure
- Package `seq_pkg` holds:
  - the state enum (IDLE, REQ, FETCH, EXEC);
  - the control bit index constants;
  - the `CTRL_W` = 13 and `ROM_ADDR_W` = 7 constants.
- Sub-module `pc_counter`: PC register with reset, load and increment, load priority, and wrap.

## Test plan
- Reset, then `run` = 1 with `prog_valid` always 1 and program byte 0x20 → PC sequence 0, 1, 2 every 3 cycles; `rom_addr` = 0b0010000 in FETCH and 0b0010001 in EXEC.
- Hold `prog_valid` low 4 cycles in REQ → `prog_req` held high, `ctrl_out` = 0 throughout, instruction completes 4 cycles late.
- EXEC with loadPC and `jmp_target` = 0x3A5 → next `pc_out` = 0x3A5, with no extra increment.
- PC = 0xFFF, FETCH with incPC → PC = 0x000.
- EXEC with loadFlags, `alu_c` = 1, `alu_z` = 0 → `flags` = 0b10 and next `rom_addr[2:1]` = 0b10. Assert `reset` during the following FETCH → IDLE, PC 0, `flags` 0 one edge later.
- With `SEQ_SINGLE_STEP_EN` and `run` = 0: one `step` pulse → exactly one REQ/FETCH/EXEC sequence then IDLE, PC advanced by 1. A second `step` while `busy` has no effect.
